// File: rtl/regfile_dump.sv
// regfile_dump: walks every register through a read port and streams it out.
// Ports: i_clk, i_reset (async, active-low), i_start, i_abort,
//   o_rd_reg/i_rd_data (register file read port),
//   o_out_data/o_out_idx/o_out_valid/i_out_ready/o_out_last (stream),
//   o_busy, o_done.
// Optional: define REGDUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_reg,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_idx,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
`ifdef REGDUMP_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

`ifdef REGDUMP_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_idx;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
`endif

  logic w_hs;
  logic w_at_last;

  assign w_hs      = r_out_valid & i_out_ready;
  assign w_at_last = (r_idx == LAST);

  // Read address is the walk index; it is parked at 0 whenever idle.
  assign o_rd_reg    = r_idx;
  assign o_out_data  = r_out_data;
  assign o_out_idx   = r_out_idx;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_acc       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      // Abort wins over any handshake; it never produces done.
      if (i_abort && r_state != S_IDLE) begin
        r_state     <= S_IDLE;
        r_idx       <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_READ;
              r_idx   <= '0;
              r_busy  <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
              r_acc   <= '0;
`endif
            end
          end
          S_READ: begin
            r_out_data  <= i_rd_data;
            r_out_idx   <= r_idx;
            r_out_valid <= 1'b1;
            r_out_last  <= w_at_last & ~CK;
`ifdef REGDUMP_CHECKSUM_EN
            r_acc       <= r_acc ^ i_rd_data;
`endif
            r_state     <= S_HOLD;
          end
          S_HOLD: begin
            if (w_hs) begin
              if (!w_at_last) begin
                r_idx       <= r_idx + ONE;
                r_out_valid <= 1'b0;
                r_state     <= S_READ;
              end else begin
`ifdef REGDUMP_CHECKSUM_EN
                // acc already folded in the last register at READ.
                r_out_data <= r_acc;
                r_out_idx  <= '0;
                r_out_last <= 1'b1;
                r_state    <= S_CKSUM;
`else
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= S_DONE;
`endif
              end
            end
          end
`ifdef REGDUMP_CHECKSUM_EN
          S_CKSUM: begin
            if (w_hs) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
`endif
          S_DONE: begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump.
// Models a 32-entry register file with a combinational read port.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NW       = CK ? 33 : 32;
  localparam int DONE_CYC = CK ? 66 : 65;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        out_ready;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_reg];

  regfile_dump dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_abort     (abort),
    .o_rd_reg    (rd_reg),
    .i_rd_data   (rd_data),
    .o_out_data  (out_data),
    .o_out_idx   (out_idx),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic seen;
    checks++;
    if ({rd_reg, out_data, out_idx, out_valid, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rd=%0d data=%h idx=%0d v=%b l=%b b=%b d=%b want all 0",
               rd_reg, out_data, out_idx, out_valid, out_last, busy, done);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || out_valid || done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: activity seen=%b want 0", seen);
    end
  endtask

  task automatic test_full_dump;
    logic ev;
    int k;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      ev = (c >= 2 && c <= 64 && c % 2 == 0) || (CK && c == 65);
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL full_valid c=%0d: got %b want %b", c, out_valid, ev);
      end
      checks++;
      if (done !== (c == DONE_CYC)) begin
        errors++;
        $display("FAIL full_done c=%0d: got %b want %b", c, done, c == DONE_CYC);
      end
      checks++;
      if (busy !== (c <= DONE_CYC)) begin
        errors++;
        $display("FAIL full_busy c=%0d: got %b want %b", c, busy, c <= DONE_CYC);
      end
      if (ev && c <= 64) begin
        k = (c - 2) / 2;
        checks++;
        if (out_idx !== k[4:0] || out_data !== 32'h100 + k ||
            out_last !== (k == 31 && !CK)) begin
          errors++;
          $display("FAIL full_word c=%0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                   c, out_idx, out_data, out_last, k, 32'h100 + k, (k == 31 && !CK));
        end
      end
      if (CK && c == 65) begin
        checks++;
        if (out_data !== 32'h0 || out_idx !== 5'd0 || out_last !== 1'b1) begin
          errors++;
          $display("FAIL full_cksum: got data=%h idx=%0d last=%b want 0 0 1",
                   out_data, out_idx, out_last);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic ok;
    logic bad;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid && out_idx == 5'd5) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_wait: word 5 seen=%b want 1", ok);
    end
    out_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 32'h105 || out_idx !== 5'd5) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got v=%b data=%h idx=%0d want 1 00000105 5",
               out_valid, out_data, out_idx);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_gap: got valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd6 || out_data !== 32'h106) begin
      errors++;
      $display("FAIL bp_next: got v=%b idx=%0d data=%h want 1 6 00000106",
               out_valid, out_idx, out_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_cleanup: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_ignored;
    int words;
    int dones;
    logic pulsed;
    words = 0;
    dones = 0;
    pulsed = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (out_valid) words++;
      if (done) dones++;
      start = out_valid && out_idx == 5'd10 && !pulsed && !out_last;
      if (start) pulsed = 1'b1;
      tick();
    end
    start = 1'b0;
    checks++;
    if (words != NW) begin
      errors++;
      $display("FAIL restart_words: got %0d want %0d", words, NW);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL restart_done: got %0d want 1", dones);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_abort;
    logic ok;
    logic seen;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid && out_idx == 5'd7) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_wait: word 7 seen=%b want 1", ok);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_last !== 1'b0 || rd_reg !== 5'd0) begin
      errors++;
      $display("FAIL abort_state: got v=%b b=%b d=%b l=%b rd=%0d want 0 0 0 0 0",
               out_valid, busy, done, out_last, rd_reg);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || out_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: activity=%b want 0", seen);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'h100) begin
      errors++;
      $display("FAIL abort_restart: got v=%b idx=%0d data=%h want 1 0 00000100",
               out_valid, out_idx, out_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic seen;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (out_valid && out_idx == 5'd20) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_wait: word 20 seen=%b want 1", ok);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rd_reg, out_data, out_idx, out_valid, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL rstmid_values: got rd=%0d data=%h idx=%0d v=%b l=%b b=%b d=%b want all 0",
               rd_reg, out_data, out_idx, out_valid, out_last, busy, done);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid || busy || done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: activity=%b want 0", seen);
    end
  endtask

  task automatic test_start_abort_idle;
    out_ready = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sa_busy: got %b want 1", busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'h100) begin
      errors++;
      $display("FAIL sa_word0: got v=%b idx=%0d data=%h want 1 0 00000100",
               out_valid, out_idx, out_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sa_abort: got b=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'h100 + k;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    #1 reset = 1'b0;
    #2;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_start_abort_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
